wb_demux_router: RTL and testbench
==================================

Name: wb_demux_router

Overview:
- Write-back demultiplexer: inverse of the result-select mux.
- Takes one 16-bit result tagged with a 3-bit destination select and routes it to one of six destination sinks (codes 0-5) using a one-hot valid/ready handshake.
- Holds up to two results in an in-order skid buffer so the execute stage is not stalled by a single-cycle sink backpressure.
- Select codes 6 and 7 are reserved. Results carrying them are consumed, dropped and counted.

Parameters:
- DATA_W, 16, width of the routed result.
- NDEST, 6, number of valid destinations; codes >= NDEST are reserved.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream result valid.
- in_ready  out  1  router can accept; equals (count < 2).
- in_data  in  DATA_W  result value.
- in_sel  in  3  destination select.
- out_valid  out  NDEST  one-hot valid toward destination in_sel of the head entry.
- out_ready  in  NDEST  per-destination ready.
- out_data  out  DATA_W  head entry data, shared by all destinations.
- drop_pulse  out  1  one-cycle pulse, registered, after a reserved-select transfer is accepted.
- drop_count  out  CNT_W  number of dropped transfers, saturating.

Behaviour:
- One clock domain. Reset is synchronous and active-high. On rst:
  - count=0, out_valid=0, out_data=0, drop_pulse=0, drop_count=0.
  - Buffer contents are discarded, including entries held in a mid-transfer state.
- Storage: 2-entry FIFO of {data, sel}, with head and tail entries and count 0..2.
- in_ready is driven only from registered count, with no combinational path from out_ready. It is low exactly when count==2.
- Push condition: in_valid & in_ready & (in_sel < NDEST). The entry is written at the tail.
- Drop condition: in_valid & in_ready & (in_sel >= NDEST).
  - The buffer is unchanged.
  - drop_pulse=1 in the next cycle only.
  - drop_count increments, holding at 2^CNT_W-1.
- Head output:
  - out_valid[k] = (count>0) & (head_sel==k). At most one bit is ever set.
  - out_data = head_data.
  - When count==0, out_data retains its last value.
- Pop condition: count>0 & out_ready[head_sel]. The other out_ready bits are ignored.
- Latency: a value accepted at edge N is presented from edge N, meaning visible in the cycle after acceptance. Minimum latency is 1 cycle; there is no combinational in-to-out path.
- Throughput: 1 transfer/cycle when the head sink keeps its ready high.
- Ordering: strict in-order delivery. A blocked head for destination A blocks a queued entry for destination B (no bypass).
- Simultaneous events:
  - Push+pop with count==1: count stays 1 and the new entry becomes head.
  - Push+pop with count==0 cannot occur, because pop requires count>0.
  - Drop+pop in the same cycle: the pop proceeds and drop is handled as above.
- Full: while count==2, in_ready=0. The upstream must hold in_valid/in_data/in_sel stable.
- Pointer wrap-around: the 1-bit read and write pointers toggle modulo 2.
- Saturation: drop_count never wraps.

Test Plan:
1. Reset then single transfer: in_sel=3, in_data=16'hA5A5, out_ready=6'b111111 → next cycle out_valid=6'b001000, out_data=A5A5; one cycle later out_valid=0.
2. Backpressure fill: out_ready=0, push sel=0 data 0x0001, sel=5 data 0x0002 → in_ready=0 after 2nd accept. Raise out_ready[0] → 0x0001 delivered with out_valid=6'b000001. Then 0x0002 waits until out_ready[5]=1 (out_valid=6'b100000).
3. Streaming: out_ready all 1, 10 back-to-back pushes with sel cycling 0..5 → 10 deliveries on consecutive cycles, in order, in_ready constantly 1.
4. Reserved selects: push sel=6 then sel=7 → no out_valid, drop_pulse high for each, drop_count=2. Force 300 drops → drop_count=255.
5. Head-of-line blocking: head sel=2 with out_ready[2]=0 and out_ready[4]=1, second entry sel=4 → nothing delivered until out_ready[2]=1. Then sel=2 is delivered first, sel=4 next cycle.
6. Reset mid-operation: count=2 and drop_count=5, assert rst one cycle → out_valid=0, in_ready=1, drop_count=0, drop_pulse=0. Stale entries are never delivered.

Source files
------------

// File: rtl/wb_demux_router.sv
// Write-back demultiplexer: routes a tagged result to one of NDEST sinks
// through a 2-entry in-order skid buffer; reserved selects are dropped and counted.
module wb_demux_router #(
    parameter int DATA_W = 16,
    parameter int NDEST  = 6,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [2:0]        in_sel,
    output logic [NDEST-1:0]  out_valid,
    input  logic [NDEST-1:0]  out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              drop_pulse,
    output logic [CNT_W-1:0]  drop_count
);

    localparam logic [2:0] NDEST_SEL = 3'(NDEST);

    logic [DATA_W-1:0] data_mem [2];
    logic [2:0]        sel_mem  [2];
    logic              wptr;
    logic              rptr;
    logic [1:0]        count;
    logic [DATA_W-1:0] last_data;
    logic              accept;
    logic              push;
    logic              drop;
    logic              pop;
    logic [2:0]        head_sel;

    // in_ready depends only on the registered fill level, never on out_ready
    assign in_ready = (count != 2'd2);
    assign accept   = in_valid & in_ready;
    assign push     = accept & (in_sel < NDEST_SEL);
    assign drop     = accept & (in_sel >= NDEST_SEL);
    assign head_sel = sel_mem[rptr];

    always_comb begin
        out_valid = '0;
        for (int k = 0; k < NDEST; k++) begin
            out_valid[k] = (count != 2'd0) && (head_sel == 3'(k));
        end
    end

    // Only the ready of the head's own destination can pop it
    assign pop      = |(out_valid & out_ready);
    assign out_data = (count != 2'd0) ? data_mem[rptr] : last_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= 2'd0;
            wptr       <= 1'b0;
            rptr       <= 1'b0;
            last_data  <= '0;
            drop_pulse <= 1'b0;
            drop_count <= '0;
            for (int i = 0; i < 2; i++) begin
                data_mem[i] <= '0;
                sel_mem[i]  <= 3'd0;
            end
        end else begin
            if (push) begin
                data_mem[wptr] <= in_data;
                sel_mem[wptr]  <= in_sel;
                wptr           <= ~wptr;
            end
            // Remember the delivered value so out_data holds it once empty
            if (pop) begin
                rptr      <= ~rptr;
                last_data <= data_mem[rptr];
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            drop_pulse <= drop;
            if (drop && (drop_count != {CNT_W{1'b1}})) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_demux_router.sv
// Self-checking bench for wb_demux_router: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_wb_demux_router;

    localparam int DATA_W = 16;
    localparam int NDEST  = 6;
    localparam int CNT_W  = 8;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [2:0]        in_sel;
    logic [NDEST-1:0]  out_valid;
    logic [NDEST-1:0]  out_ready;
    logic [DATA_W-1:0] out_data;
    logic              drop_pulse;
    logic [CNT_W-1:0]  drop_count;

    wb_demux_router #(.DATA_W(DATA_W), .NDEST(NDEST), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_sel(in_sel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .drop_pulse(drop_pulse),
        .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [2:0]        sel;
    } entry_t;

    entry_t q[$];
    logic [DATA_W-1:0] mLast;
    int                mDrops;
    logic              mPulse;
    bit                lastAccepted;

    int passCount = 0;
    int totalCount = 0;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCount++;
        assert (obs === exp) begin
            passCount++;
        end else begin
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the reference model state
    task automatic checkOutput();
        logic [NDEST-1:0]  expValid;
        logic [DATA_W-1:0] expData;
        expValid = '0;
        expData  = mLast;
        if (q.size() > 0) begin
            expValid[q[0].sel] = 1'b1;
            expData            = q[0].data;
        end
        checkVal("out_valid", 32'(out_valid), 32'(expValid));
        checkVal("out_data", 32'(out_data), 32'(expData));
        checkVal("in_ready", 32'(in_ready), 32'(q.size() < 2));
        checkVal("drop_pulse", 32'(drop_pulse), 32'(mPulse));
        checkVal("drop_count", 32'(drop_count), 32'(mDrops));
    endtask

    // One clock: check at negedge, advance the model with the held inputs
    task automatic cycle();
        bit acc;
        bit popIt;
        @(negedge clk);
        if (!rst) checkOutput();
        acc   = in_valid && (q.size() < 2);
        popIt = (q.size() > 0) && out_ready[q[0].sel];
        @(posedge clk);
        if (rst) begin
            q.delete();
            mLast  = '0;
            mDrops = 0;
            mPulse = 1'b0;
            lastAccepted = 1'b1;
        end else begin
            if (popIt) begin
                mLast = q[0].data;
                void'(q.pop_front());
            end
            mPulse = acc && (in_sel >= 3'(NDEST));
            if (acc && in_sel < 3'(NDEST)) q.push_back('{data: in_data, sel: in_sel});
            if (mPulse && mDrops < 255) mDrops++;
            lastAccepted = acc || !in_valid;
        end
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d,
                                 input logic [2:0] s, input logic [NDEST-1:0] r);
        in_valid  = v;
        in_data   = d;
        in_sel    = s;
        out_ready = r;
        cycle();
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, '0, 3'd0, '0);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL timeout simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = 3'd0; out_ready = '0;
        mLast = '0; mDrops = 0; mPulse = 1'b0; lastAccepted = 1'b1;
        @(posedge clk); #1;
        doReset();

        // Reset state
        checkVal("rst_valid", 32'(out_valid), 32'h0);
        checkVal("rst_ready", 32'(in_ready), 32'h1);
        checkVal("rst_data", 32'(out_data), 32'h0);
        checkVal("rst_dcount", 32'(drop_count), 32'h0);

        // Single transfer
        applyStimulus(1'b1, 16'hA5A5, 3'd3, 6'b111111);
        checkVal("t1_valid", 32'(out_valid), 32'h08);
        checkVal("t1_data", 32'(out_data), 32'hA5A5);
        applyStimulus(1'b0, 16'h0, 3'd0, 6'b111111);
        checkVal("t1_empty", 32'(out_valid), 32'h0);
        checkVal("t1_hold", 32'(out_data), 32'hA5A5);

        // Backpressure fill
        applyStimulus(1'b1, 16'h0001, 3'd0, 6'b000000);
        applyStimulus(1'b1, 16'h0002, 3'd5, 6'b000000);
        checkVal("t2_full", 32'(in_ready), 32'h0);
        applyStimulus(1'b0, 16'h0, 3'd0, 6'b000000);
        checkVal("t2_head", 32'(out_valid), 32'h01);
        applyStimulus(1'b0, 16'h0, 3'd0, 6'b000001);
        checkVal("t2_second", 32'(out_valid), 32'h20);
        checkVal("t2_sdata", 32'(out_data), 32'h0002);
        applyStimulus(1'b0, 16'h0, 3'd0, 6'b011111);
        checkVal("t2_wait", 32'(out_valid), 32'h20);
        applyStimulus(1'b0, 16'h0, 3'd0, 6'b100000);
        checkVal("t2_drained", 32'(out_valid), 32'h0);

        // Streaming
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 16'(16'h100 + i), 3'(i % 6), 6'b111111);
            checkVal("t3_data", 32'(out_data), 32'(16'h100 + i));
        end
        applyStimulus(1'b0, 16'h0, 3'd0, 6'b111111);

        // Reserved selects and saturation
        applyStimulus(1'b1, 16'hDEAD, 3'd6, 6'b111111);
        checkVal("t4_pulse6", 32'(drop_pulse), 32'h1);
        applyStimulus(1'b1, 16'hBEEF, 3'd7, 6'b111111);
        checkVal("t4_pulse7", 32'(drop_pulse), 32'h1);
        checkVal("t4_count2", 32'(drop_count), 32'h2);
        checkVal("t4_novalid", 32'(out_valid), 32'h0);
        applyStimulus(1'b0, 16'h0, 3'd0, 6'b111111);
        checkVal("t4_pulseoff", 32'(drop_pulse), 32'h0);
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 16'($urandom), 3'($urandom_range(6, 7)), 6'b111111);
        end
        checkVal("t4_sat", 32'(drop_count), 32'hFF);

        // Head-of-line blocking
        applyStimulus(1'b1, 16'h2222, 3'd2, 6'b010000);
        applyStimulus(1'b1, 16'h4444, 3'd4, 6'b010000);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 16'h0, 3'd0, 6'b010000);
            checkVal("t5_blocked", 32'(out_valid), 32'h04);
        end
        applyStimulus(1'b0, 16'h0, 3'd0, 6'b010100);
        checkVal("t5_next", 32'(out_valid), 32'h10);
        checkVal("t5_ndata", 32'(out_data), 32'h4444);
        applyStimulus(1'b0, 16'h0, 3'd0, 6'b010100);
        checkVal("t5_empty", 32'(out_valid), 32'h0);

        // Reset mid-operation
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 16'h0, 3'd7, 6'b000000);
        applyStimulus(1'b1, 16'h1111, 3'd1, 6'b000000);
        applyStimulus(1'b1, 16'h3333, 3'd3, 6'b000000);
        checkVal("t6_prefull", 32'(in_ready), 32'h0);
        checkVal("t6_precount", 32'(drop_count), 32'h5);
        doReset();
        checkVal("t6_valid", 32'(out_valid), 32'h0);
        checkVal("t6_ready", 32'(in_ready), 32'h1);
        checkVal("t6_dcount", 32'(drop_count), 32'h0);
        checkVal("t6_pulse", 32'(drop_pulse), 32'h0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0, 3'd0, 6'b111111);

        // Randomized traffic; a stalled offer is held stable
        for (int i = 0; i < 400; i++) begin
            logic              v;
            logic [DATA_W-1:0] d;
            logic [2:0]        s;
            if (lastAccepted) begin
                v = ($urandom_range(0, 3) != 0);
                d = 16'($urandom);
                s = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            end else begin
                v = in_valid;
                d = in_data;
                s = in_sel;
            end
            applyStimulus(v, d, s, 6'($urandom));
        end
        applyStimulus(1'b0, 16'h0, 3'd0, 6'b111111);
        applyStimulus(1'b0, 16'h0, 3'd0, 6'b111111);
        applyStimulus(1'b0, 16'h0, 3'd0, 6'b111111);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
